obi_rr_arbiter: RTL

Round-robin arbiter that shares one OBI slave port (the SPI controller's register/command port) between `N_MASTERS` OBI masters, such as the test/command master and a DMA engine. It forwards address-phase requests with zero added latency and holds the selection stable while the slave stalls. It tracks outstanding transactions in an ID FIFO so each response phase returns to the master that issued it.

---
 rtl/obi_pkg.sv | 18 +
 rtl/obi_rr_arbiter_if.sv | 17 +
 rtl/obi_id_fifo.sv | 36 +++
 rtl/obi_rr_arbiter.sv | 66 ++++++
 4 files changed

// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI widths, request/response structs and ID sizing helper
package obi_pkg;
  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  typedef struct packed {
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;
  typedef struct packed {
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/obi_rr_arbiter_if.sv
// obi_rr_arbiter_if: N_PORTS-wide OBI bus; rdata is shared by all ports
interface obi_rr_arbiter_if import obi_pkg::*; #(
  parameter int N_PORTS    = 1,
  parameter int ADDR_WIDTH = OBI_ADDR_W,
  parameter int DATA_WIDTH = OBI_DATA_W
);
  logic [N_PORTS-1:0]                   req;
  logic [N_PORTS-1:0]                   gnt;
  logic [N_PORTS-1:0]                   we;
  logic [N_PORTS-1:0]                   rvalid;
  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]   addr;
  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0] be;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]                rdata;
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/obi_id_fifo.sv
// obi_id_fifo: synchronous FIFO of master IDs for outstanding OBI transfers
module obi_id_fifo import obi_pkg::*; #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = id_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk_i) if (push) mem[wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin N-to-1 OBI arbiter with stall lock and in-order response routing
module obi_rr_arbiter import obi_pkg::*; #(
  parameter int ADDR_WIDTH      = OBI_ADDR_W,
  parameter int DATA_WIDTH      = OBI_DATA_W,
  parameter int N_MASTERS       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  obi_rr_arbiter_if.slave   m,
  obi_rr_arbiter_if.master  s,
  output logic              err_o
);
  localparam int IW = id_width(N_MASTERS);
  localparam logic [IW-1:0] LAST = IW'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] ONE = N_MASTERS'(1);
  logic [IW-1:0] rr_ptr, rr_sel, lock_idx, sel, head;
  logic          locked, accept, drop, pop, full, empty;
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
    return IW'((int'(a) + b) % N_MASTERS);
  endfunction
  // scan downward so the requester closest to rr_ptr is assigned last and wins
  always_comb begin
    rr_sel = rr_ptr;
    for (int i = N_MASTERS - 1; i >= 0; i--)
      if (m.req[wrap_add(rr_ptr, i)]) rr_sel = wrap_add(rr_ptr, i);
  end
  assign sel        = locked ? lock_idx : rr_sel;
  assign s.req[0]   = !rst_i && m.req[sel] && !full;
  assign s.addr[0]  = m.addr[sel];
  assign s.we[0]    = m.we[sel];
  assign s.be[0]    = m.be[sel];
  assign s.wdata[0] = m.wdata[sel];
  assign accept     = s.req[0] && s.gnt[0];
  assign m.gnt      = accept ? ONE << sel : '0;
  assign pop        = s.rvalid[0] && !empty;
  assign m.rvalid   = (pop && !rst_i) ? ONE << head : '0;
  assign m.rdata    = s.rdata;
  assign drop       = locked && !m.req[lock_idx];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
      err_o    <= 1'b0;
    end else begin
      if (accept) rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
      if (drop || accept) locked <= 1'b0;
      else if (s.req[0]) begin
        locked   <= 1'b1;
        lock_idx <= sel;
      end
      if (drop || (s.rvalid[0] && empty)) err_o <= 1'b1;
    end
  end
  obi_id_fifo #(.WIDTH(IW), .DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (accept),
    .pop   (pop),
    .wdata (sel),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
endmodule
